// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes,
// datapath mux encodings and the bundled control-word type.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore output decode: control word as a pure function of the current state;
// opcode only picks the zero-test polarity while branching.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_write  = 1'b1;
            end
            S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH2;
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.i_or_d     = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.pc_write_cond = 1'b1;
                ctrl.instr_done    = 1'b1;
                ctrl.branch_ne     = (opcode == OP_BNE);
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle MIPS CPU: sequences fetch/decode/execute
// and drives every datapath enable and mux select from the state register.
module multicycle_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter bit ENABLE_BNE = 1'b1,
    parameter int STATE_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    output logic [STATE_W-1:0] state,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               branch_ne,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               instr_done,
    output logic               illegal_op
);

    state_t state_reg, state_next;
    logic   illegal_reg, illegal_next;
    ctrl_t  dec_ctrl, ctrl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_FETCH;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            illegal_reg <= illegal_next;
        end
    end

    always_comb begin
        state_next   = S_FETCH;
        illegal_next = illegal_reg;
        case (state_reg)
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_BNE: begin
                        if (ENABLE_BNE) state_next = S_BRANCH;
                        else            illegal_next = 1'b1;
                    end
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default:      illegal_next = 1'b1;
                endcase
            end
            S_MEMADR:  state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_next = S_MEMWB;
            S_EXECUTE: state_next = S_ALUWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            default:   state_next = S_FETCH;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .state  (state_reg),
        .opcode (opcode),
        .ctrl   (dec_ctrl)
    );

    // FETCH's enables would otherwise be live during reset; blank everything
    // combinationally so no write can slip out while rst is high.
    assign ctrl = rst ? '0 : dec_ctrl;

    assign state         = state_reg;
    assign illegal_op    = illegal_reg;
    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign branch_ne     = ctrl.branch_ne;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign instr_done    = ctrl.instr_done;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for the multi-cycle control FSM: one instance with bne
// enabled, one with bne disabled, checked every cycle on the falling edge.
module tb_multicycle_control_fsm;

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] ctl;   // pcw pcwc iord mr mw irw m2r rdst rw asa asb aop psrc done
        logic        bne;
        logic        ill;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opc1, opc0;

    logic [3:0] state1, state0;
    logic pc_write1, pc_write_cond1, branch_ne1, i_or_d1, mem_read1, mem_write1, ir_write1;
    logic mem_to_reg1, reg_dst1, reg_write1, alu_src_a1, instr_done1, illegal_op1;
    logic [1:0] alu_src_b1, alu_op1, pc_source1;
    logic pc_write0, pc_write_cond0, branch_ne0, i_or_d0, mem_read0, mem_write0, ir_write0;
    logic mem_to_reg0, reg_dst0, reg_write0, alu_src_a0, instr_done0, illegal_op0;
    logic [1:0] alu_src_b0, alu_op0, pc_source0;

    rec_t q1[$], q0[$];
    rec_t act1, act0, e1, e0;
    int   checks = 0;
    int   errors = 0;
    int   drain_cnt = 0;
    bit   drain_req = 1'b0;
    bit   mon_done = 1'b0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.ENABLE_BNE(1'b1), .STATE_W(4)) dut1 (
        .clk(clk), .rst(rst), .opcode(opc1), .state(state1),
        .pc_write(pc_write1), .pc_write_cond(pc_write_cond1), .branch_ne(branch_ne1),
        .i_or_d(i_or_d1), .mem_read(mem_read1), .mem_write(mem_write1), .ir_write(ir_write1),
        .mem_to_reg(mem_to_reg1), .reg_dst(reg_dst1), .reg_write(reg_write1),
        .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .alu_op(alu_op1),
        .pc_source(pc_source1), .instr_done(instr_done1), .illegal_op(illegal_op1)
    );

    multicycle_control_fsm #(.ENABLE_BNE(1'b0), .STATE_W(4)) dut0 (
        .clk(clk), .rst(rst), .opcode(opc0), .state(state0),
        .pc_write(pc_write0), .pc_write_cond(pc_write_cond0), .branch_ne(branch_ne0),
        .i_or_d(i_or_d0), .mem_read(mem_read0), .mem_write(mem_write0), .ir_write(ir_write0),
        .mem_to_reg(mem_to_reg0), .reg_dst(reg_dst0), .reg_write(reg_write0),
        .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .alu_op(alu_op0),
        .pc_source(pc_source0), .instr_done(instr_done0), .illegal_op(illegal_op0)
    );

    assign act1 = {state1, pc_write1, pc_write_cond1, i_or_d1, mem_read1, mem_write1, ir_write1,
                   mem_to_reg1, reg_dst1, reg_write1, alu_src_a1, alu_src_b1, alu_op1,
                   pc_source1, instr_done1, branch_ne1, illegal_op1};
    assign act0 = {state0, pc_write0, pc_write_cond0, i_or_d0, mem_read0, mem_write0, ir_write0,
                   mem_to_reg0, reg_dst0, reg_write0, alu_src_a0, alu_src_b0, alu_op0,
                   pc_source0, instr_done0, branch_ne0, illegal_op0};

    // Hand-written control word per state, straight from the state table.
    function automatic logic [16:0] exp_ctl(input logic [3:0] st);
        case (st)
            4'd0:    return 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
            4'd1:    return 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
            4'd2:    return 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
            4'd3:    return 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
            4'd4:    return 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_1;
            4'd5:    return 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_1;
            4'd6:    return 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
            4'd7:    return 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_1;
            4'd8:    return 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_1;
            4'd9:    return 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
            4'd10:   return 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_1;
            4'd11:   return 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_1;
            default: return 17'b0;
        endcase
    endfunction

    function automatic rec_t mk(input logic [3:0] st, input logic bne, input logic ill);
        rec_t r;
        r.st  = st;
        r.ctl = exp_ctl(st);
        r.bne = bne;
        r.ill = ill;
        return r;
    endfunction

    task automatic push(input bit which, input rec_t r);
        if (which) q1.push_back(r);
        else       q0.push_back(r);
    endtask

    // Issue one instruction: queue the expected per-cycle records, then let it run.
    task automatic run_instr(input bit which, input logic [5:0] opc, input int n,
                             input logic [0:4][3:0] seq, input logic ill);
        if (which) opc1 = opc;
        else       opc0 = opc;
        for (int k = 0; k < n; k++)
            push(which, mk(seq[k], (seq[k] == 4'd8) && (opc == 6'b000101), ill));
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            checks++;
            if (act1 !== e1) begin
                errors++;
                $display("FAIL bne_on t=%0t: got st=%0d ctl=%b bne=%b ill=%b, expected st=%0d ctl=%b bne=%b ill=%b",
                         $time, act1.st, act1.ctl, act1.bne, act1.ill, e1.st, e1.ctl, e1.bne, e1.ill);
            end else
                $display("check bne_on t=%0t st=%0d ctl=%b bne=%b ill=%b ok", $time, act1.st, act1.ctl, act1.bne, act1.ill);
        end
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            checks++;
            if (act0 !== e0) begin
                errors++;
                $display("FAIL bne_off t=%0t: got st=%0d ctl=%b bne=%b ill=%b, expected st=%0d ctl=%b bne=%b ill=%b",
                         $time, act0.st, act0.ctl, act0.bne, act0.ill, e0.st, e0.ctl, e0.bne, e0.ill);
            end else
                $display("check bne_off t=%0t st=%0d ctl=%b bne=%b ill=%b ok", $time, act0.st, act0.ctl, act0.bne, act0.ill);
        end
        if (drain_req && !mon_done) begin
            if (q1.size() == 0 && q0.size() == 0)
                mon_done = 1'b1;
            else if (++drain_cnt > 20) begin
                checks++;
                errors++;
                $display("FAIL drain: got %0d records left, expected 0", q1.size() + q0.size());
                mon_done = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst  = 1'b0;
        opc1 = 6'b000000;
        opc0 = 6'b000000;
        #3 rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            push(1'b1, rec_t'(0));
            push(1'b0, rec_t'(0));
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        fork
            begin
                run_instr(1'b1, 6'b100011, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4},  1'b0); // lw
                run_instr(1'b1, 6'b101011, 4, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0},  1'b0); // sw
                run_instr(1'b1, 6'b000000, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0},  1'b0); // R-type
                run_instr(1'b1, 6'b001000, 4, {4'd0, 4'd1, 4'd9, 4'd10, 4'd0}, 1'b0); // addi
                run_instr(1'b1, 6'b000010, 3, {4'd0, 4'd1, 4'd11, 4'd0, 4'd0}, 1'b0); // j
                run_instr(1'b1, 6'b000100, 3, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0},  1'b0); // beq
                run_instr(1'b1, 6'b000101, 3, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0},  1'b0); // bne
                run_instr(1'b1, 6'b111111, 2, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0},  1'b0); // illegal
                run_instr(1'b1, 6'b100011, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4},  1'b1); // lw, flag sticky
            end
            begin
                run_instr(1'b0, 6'b000101, 2, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0},  1'b0); // bne disabled
                run_instr(1'b0, 6'b100011, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4},  1'b1);
            end
        join

        // lw interrupted by reset in MEMRD: async jump to FETCH, flag cleared.
        opc1 = 6'b100011;
        push(1'b1, mk(4'd0, 1'b0, 1'b1));
        push(1'b1, mk(4'd1, 1'b0, 1'b1));
        push(1'b1, mk(4'd2, 1'b0, 1'b1));
        push(1'b1, rec_t'(0));
        push(1'b1, rec_t'(0));
        push(1'b1, mk(4'd1, 1'b0, 1'b0));
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #6 rst = 1'b0;

        drain_req = 1'b1;
        wait (mon_done);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
